// File: rtl/icache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Addresses are word addresses: [1:0] word, then index, then tag.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
        return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
        return addr >> (idx_w + 2);
    endfunction

    function automatic logic [1:0] addr_word(input logic [31:0] addr);
        return addr[1:0];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one combinational read port, one write port, synchronous clear of valid bits.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IDX_W = 2,
    parameter int TAG_W = 28
) (
    input  logic                clock,
    input  logic                clear_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    input  logic [TAG_W-1:0]    rd_tag_i,
    input  logic [1:0]          rd_word_i,
    output logic                hit_o,
    output logic [WORD_W-1:0]   rd_data_o,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [LINE_W-1:0]   wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] rd_line;

    // A write in the same cycle as a clear still leaves its own line valid.
    always_ff @(posedge clock) begin
        if (clear_i) begin
            valid_q <= '0;
        end
        if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_line = data_q[rd_idx_i];
        hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
        case (rd_word_i)
            2'd0:    rd_data_o = rd_line[31:0];
            2'd1:    rd_data_o = rd_line[63:32];
            2'd2:    rd_data_o = rd_line[95:64];
            default: rd_data_o = rd_line[127:96];
        endcase
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, stall-and-fill misses from instruction_mem.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    input  logic          flush,
    output logic [31:0]   instr,
    output logic          stall,
    output logic          mem_enable,
    output logic [31:0]   mem_address,
    input  logic [127:0]  mem_data,
    input  logic          mem_valid,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count,
    output logic [1:0]    state_dbg
);

    localparam int TAG_W = 30 - IDX_W;

    state_e      state_q;
    logic [29:0] miss_line_q;
    logic        mem_enable_q;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [1:0]        lk_word;
    logic              store_hit;
    logic [WORD_W-1:0] store_word;
    logic              hit;
    logic              miss_start;
    logic              fill_en;

    assign lk_idx  = IDX_W'(addr_index(fetch_addr, IDX_W));
    assign lk_tag  = TAG_W'(addr_tag(fetch_addr, IDX_W));
    assign lk_word = addr_word(fetch_addr);

    assign hit        = fetch_req && (state_q == IDLE) && store_hit;
    assign miss_start = fetch_req && (state_q == IDLE) && !store_hit;
    assign fill_en    = !reset && (state_q == WAIT) && mem_valid;

    assign instr       = hit ? store_word : '0;
    assign stall       = (state_q != IDLE) || (fetch_req && !hit);
    assign mem_enable  = mem_enable_q;
    assign mem_address = {miss_line_q, 2'b00};
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;
    assign state_dbg   = state_q;

    icache_line_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clock     (clock),
        .clear_i   (reset || flush),
        .rd_idx_i  (lk_idx),
        .rd_tag_i  (lk_tag),
        .rd_word_i (lk_word),
        .hit_o     (store_hit),
        .rd_data_o (store_word),
        .wr_en_i   (fill_en),
        .wr_idx_i  (miss_line_q[IDX_W-1:0]),
        .wr_tag_i  (miss_line_q[29:IDX_W]),
        .wr_data_i (mem_data)
    );

    // Memory handshake: a read starts on a 0->1 edge of mem_enable; REQ forces one low cycle
    // first, mem_enable then holds high until the cycle mem_valid is seen, and drops on that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_line_q  <= '0;
            mem_enable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        state_q      <= REQ;
                        miss_line_q  <= fetch_addr[31:2];
                        mem_enable_q <= 1'b0;
                    end
                end
                REQ: begin
                    state_q      <= WAIT;
                    mem_enable_q <= 1'b1;
                end
                WAIT: begin
                    if (mem_valid) begin
                        state_q      <= IDLE;
                        mem_enable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    mem_enable_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && hit_count_q != 16'hFFFF) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_start && miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache with a fixed-latency instruction_mem model.
module tb_instruction_cache;
    import icache_pkg::*;

    localparam int LAT        = 10;
    localparam int MISS_STALL = 3 + LAT;
    localparam int LIMIT      = 200;

    logic         clock, reset, fetch_req, flush;
    logic [31:0]  fetch_addr, instr, mem_address;
    logic         stall, mem_enable, mem_valid;
    logic [127:0] mem_data;
    logic [15:0]  hit_count, miss_count;
    logic [1:0]   state_dbg;

    logic         model_valid, stray_valid;
    logic [127:0] model_data, stray_data;

    int vectors, miscompares;
    int exp_hits, exp_misses;
    int rises;
    logic [31:0] exp_q[$];

    assign mem_valid = model_valid | stray_valid;
    assign mem_data  = stray_valid ? stray_data : model_data;

    instruction_cache #(.LINES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .flush       (flush),
        .instr       (instr),
        .stall       (stall),
        .mem_enable  (mem_enable),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1357_0000 + a * 32'h0001_0001;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] base);
        logic [31:0] b;
        b = {base[31:2], 2'b00};
        return {mem_word(b + 32'd3), mem_word(b + 32'd2), mem_word(b + 32'd1), mem_word(b)};
    endfunction

    // instruction_mem model: mem_valid LAT cycles after each rising edge of mem_enable
    initial begin : mem_model
        int cnt;
        bit busy;
        logic prev_en;
        logic [31:0] req_addr;
        cnt = 0;
        busy = 0;
        prev_en = 1'b0;
        req_addr = '0;
        model_valid = 1'b0;
        model_data = '0;
        forever begin
            @(negedge clock);
            model_valid = 1'b0;
            if (reset) begin
                busy = 0;
                prev_en = 1'b0;
            end else begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_valid = 1'b1;
                        model_data = mem_line(req_addr);
                        busy = 0;
                    end
                end else if (mem_enable && !prev_en) begin
                    busy = 1;
                    cnt = LAT;
                    req_addr = mem_address;
                    rises++;
                end
                prev_en = mem_enable;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic apply_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        fetch_req = 1'b0;
        flush = 1'b0;
        stray_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic idle(input int n);
        fetch_req = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Holds the fetch until the cache stops stalling, then scores the returned word.
    task automatic do_fetch(input logic [31:0] a, input bit exp_hit, input int flush_at);
        int st;
        bit seen_en;
        logic [31:0] exp_w;
        exp_q.push_back(mem_word(a));
        fetch_addr = a;
        fetch_req = 1'b1;
        flush = (flush_at == 0);
        st = 0;
        seen_en = 0;
        #2;
        while (stall && st < LIMIT) begin
            if (mem_enable && !seen_en) begin
                seen_en = 1;
                vectors++;
                if (mem_address !== {a[31:2], 2'b00}) begin
                    miscompares++;
                    $display("FAIL mem_address @%h: got %h expected %h", a, mem_address, {a[31:2], 2'b00});
                end
            end
            @(negedge clock);
            flush = (st + 1 == flush_at);
            #2;
            st++;
        end
        vectors++;
        if (st !== (exp_hit ? 0 : MISS_STALL)) begin
            miscompares++;
            $display("FAIL stall_cycles @%h: got %0d expected %0d", a, st, exp_hit ? 0 : MISS_STALL);
        end
        if (!exp_hit) begin
            vectors++;
            if (!seen_en) begin
                miscompares++;
                $display("FAIL mem_request @%h: got no mem_enable expected one", a);
            end
        end
        exp_w = exp_q.pop_front();
        vectors++;
        if (instr !== exp_w) begin
            miscompares++;
            $display("FAIL instr @%h: got %h expected %h", a, instr, exp_w);
        end
        exp_hits++;
        if (!exp_hit) exp_misses++;
        @(negedge clock);
        flush = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        apply_reset();
        fetch_addr = 32'h10;
        #2;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall); end
        vectors++; if (mem_enable !== 1'b0) begin miscompares++; $display("FAIL reset_mem_enable: got %b expected 0", mem_enable); end
        vectors++; if (mem_address !== 32'h0) begin miscompares++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", instr); end
        vectors++; if (hit_count !== 16'h0) begin miscompares++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
        vectors++; if (miss_count !== 16'h0) begin miscompares++; $display("FAIL reset_miss_count: got %0d expected 0", miss_count); end
        vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    task automatic test_cold_miss();
        int r0;
        apply_reset();
        r0 = rises;
        do_fetch(32'h10, 1'b0, -1);
        vectors++; if (miss_count !== 16'(exp_misses)) begin miscompares++; $display("FAIL cold_miss_count: got %0d expected %0d", miss_count, exp_misses); end
        vectors++; if (hit_count !== 16'(exp_hits)) begin miscompares++; $display("FAIL cold_hit_count: got %0d expected %0d", hit_count, exp_hits); end
        vectors++; if (rises - r0 !== 1) begin miscompares++; $display("FAIL cold_rises: got %0d expected 1", rises - r0); end
    endtask

    task automatic test_sequential_hits();
        int r0;
        r0 = rises;
        for (int i = 1; i < 4; i++) do_fetch(32'h10 + 32'(i), 1'b1, -1);
        vectors++; if (mem_enable !== 1'b0) begin miscompares++; $display("FAIL seq_mem_enable: got %b expected 0", mem_enable); end
        vectors++; if (rises - r0 !== 0) begin miscompares++; $display("FAIL seq_rises: got %0d expected 0", rises - r0); end
        vectors++; if (hit_count !== 16'(exp_hits)) begin miscompares++; $display("FAIL seq_hit_count: got %0d expected %0d", hit_count, exp_hits); end
        vectors++; if (miss_count !== 16'(exp_misses)) begin miscompares++; $display("FAIL seq_miss_count: got %0d expected %0d", miss_count, exp_misses); end
        idle(2);
    endtask

    task automatic test_conflict();
        int r0;
        apply_reset();
        r0 = rises;
        do_fetch(32'h10, 1'b0, -1);
        do_fetch(32'h50, 1'b0, -1);
        do_fetch(32'h10, 1'b0, -1);
        idle(2);
        vectors++; if (miss_count !== 16'd3) begin miscompares++; $display("FAIL conflict_miss_count: got %0d expected 3", miss_count); end
        vectors++; if (rises - r0 !== 3) begin miscompares++; $display("FAIL conflict_rises: got %0d expected 3", rises - r0); end
    endtask

    task automatic test_back_to_back();
        int r0;
        apply_reset();
        r0 = rises;
        do_fetch(32'h20, 1'b0, -1);
        do_fetch(32'h34, 1'b0, -1);
        idle(2);
        vectors++; if (rises - r0 !== 2) begin miscompares++; $display("FAIL b2b_rises: got %0d expected 2", rises - r0); end
        vectors++; if (miss_count !== 16'(exp_misses)) begin miscompares++; $display("FAIL b2b_miss_count: got %0d expected %0d", miss_count, exp_misses); end
    endtask

    task automatic test_flush();
        apply_reset();
        do_fetch(32'h10, 1'b0, -1);
        do_fetch(32'h24, 1'b0, 5);
        do_fetch(32'h24, 1'b1, -1);
        do_fetch(32'h10, 1'b0, -1);
        do_fetch(32'h11, 1'b1, 0);
        do_fetch(32'h11, 1'b0, -1);
        idle(2);
        vectors++; if (hit_count !== 16'(exp_hits)) begin miscompares++; $display("FAIL flush_hit_count: got %0d expected %0d", hit_count, exp_hits); end
        vectors++; if (miss_count !== 16'(exp_misses)) begin miscompares++; $display("FAIL flush_miss_count: got %0d expected %0d", miss_count, exp_misses); end
    endtask

    task automatic test_reset_mid_miss();
        apply_reset();
        fetch_addr = 32'h30;
        fetch_req = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        reset = 1'b1;
        fetch_req = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL rst_mid_state: got %0d expected %0d", state_dbg, IDLE); end
        vectors++; if (mem_enable !== 1'b0) begin miscompares++; $display("FAIL rst_mid_mem_enable: got %b expected 0", mem_enable); end
        vectors++; if (miss_count !== 16'h0) begin miscompares++; $display("FAIL rst_mid_miss_count: got %0d expected 0", miss_count); end
        @(negedge clock);
        stray_data = ~mem_line(32'h30);
        stray_valid = 1'b1;
        @(negedge clock);
        stray_valid = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        #2;
        vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL stray_state: got %0d expected %0d", state_dbg, IDLE); end
        vectors++; if (mem_enable !== 1'b0) begin miscompares++; $display("FAIL stray_mem_enable: got %b expected 0", mem_enable); end
        vectors++; if (hit_count !== 16'h0) begin miscompares++; $display("FAIL stray_hit_count: got %0d expected 0", hit_count); end
        vectors++; if (miss_count !== 16'h0) begin miscompares++; $display("FAIL stray_miss_count: got %0d expected 0", miss_count); end
        exp_hits = 0;
        exp_misses = 0;
        do_fetch(32'h30, 1'b0, -1);
        do_fetch(32'h00, 1'b0, -1);
        idle(1);
        vectors++; if (miss_count !== 16'(exp_misses)) begin miscompares++; $display("FAIL stray_after_miss_count: got %0d expected %0d", miss_count, exp_misses); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rises = 0;
        exp_hits = 0;
        exp_misses = 0;
        reset = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = '0;
        flush = 1'b0;
        stray_valid = 1'b0;
        stray_data = '0;

        test_reset();
        test_cold_miss();
        test_sequential_hits();
        test_conflict();
        test_back_to_back();
        test_flush();
        test_reset_mid_miss();

        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the fetch stage and `instruction_mem`. On a hit it returns the 32-bit instruction in the same cycle. On a miss it stalls fetch and runs the rising-edge `enable` / `valid` handshake that `instruction_mem` requires. It then fills a 128-bit (4-word) line and resumes. Hit and miss counts are kept for performance measurement.

## Interface
- `LINES`, 4: number of lines; power of two, ≥2.
- `IDX_W`, $clog2(LINES): index width (derived).
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `fetch_req` input 1: fetch wants an instruction this cycle.
- `fetch_addr` input 32: word address; [1:0] word-in-line, [IDX_W+1:2] index, [31:IDX_W+2] tag.
- `flush` input 1: invalidate all lines (single-cycle pulse).
- `instr` output 32: selected word; valid when `fetch_req && !stall`.
- `stall` output 1: fetch must hold `fetch_addr` and `fetch_req`.
- `mem_enable` output 1: read request to `instruction_mem`; a 0→1 edge starts a read.
- `mem_address` output 32: latched miss address, [1:0] forced to 0.
- `mem_data` input 128: returned line; word n in bits [32n+31:32n].
- `mem_valid` input 1: `mem_data` valid this cycle.
- `hit_count`, `miss_count` output 16 each: saturating counters.

## Operation
- Storage: per line, a valid bit, a tag, and 128 data bits. Valid bits are registers; all are cleared by `reset` or `flush`.
- Hit: `fetch_req && state==IDLE && valid[idx] && tag[idx]==fetch_addr tag`. Combinational, no added cycle.
- States:
  - **IDLE**: on `fetch_req` && miss, latch the address into `miss_addr` and go to REQ. `stall` is 1 combinationally in the miss cycle.
  - **REQ**: one cycle with `mem_enable`=0. This guarantees the low cycle needed for a fresh rising edge. Go to WAIT.
  - **WAIT**: `mem_enable`=1. On `mem_valid`, write the line at `miss_addr` index, set tag and valid, and go to IDLE. `mem_enable` drops in the same edge.
- `stall` = `state!=IDLE || (fetch_req && !hit)`.
- After a fill, the IDLE cycle re-evaluates the current `fetch_addr` as a normal lookup. A fill into a conflicting index evicts silently.
- `mem_valid` outside WAIT is ignored; no write and no state change.
- `flush` in WAIT clears all valid bits. The in-flight fill still completes and sets its own line valid.
- `flush` and a hit in the same cycle: the hit is served, and the valid clear takes effect at the edge.
- Counters: `hit_count` increments on each cycle with `fetch_req && hit`. `miss_count` increments once per IDLE→REQ. Both saturate at 0xFFFF and are cleared by `reset` only.
- No timeout: WAIT holds until `mem_valid`.

## Timing
- Reset values: `stall`=0 (when `fetch_req`=0), `mem_enable`=0, `mem_address`=0, `instr`=0 (all lines read as 0 after reset), counters 0, state IDLE, all valid bits 0.
- Hit latency: 0 cycles, combinational from `fetch_addr`.
- Miss sequence:
  - Cycle 0: miss detected.
  - Cycle 1: REQ.
  - Cycle 2: `mem_enable` rises.
  - Cycle k: `mem_valid` in WAIT.
  - Cycle k+1: IDLE, hit, `instr` valid.
- Miss penalty = (k − 0) + 1 cycles. With `instruction_mem`, `mem_valid` arrives a fixed number of cycles after the rising edge.
- `mem_address` is registered and stable from REQ through WAIT.
- Reset mid-miss: next cycle is IDLE with `mem_enable`=0. A later stale `mem_valid` is ignored.

## Structure
- Package `icache_pkg`:
  - state enum {IDLE, REQ, WAIT}
  - `WORD_W`=32, `LINE_W`=128, `WORDS_PER_LINE`=4
  - helper functions `addr_index`, `addr_tag`, `addr_word`
- Sub-module `icache_line_store`: valid/tag/data arrays with one combinational read port, one write port, and a synchronous clear. It returns `hit` and the selected word.
- Top level: FSM, miss latch, counters, memory handshake.

## Test plan
- Cold miss:
  - Stimulus: reset, then `fetch_req`=1 at `fetch_addr`=0x10, with a memory model of fixed 10-cycle latency returning words {A0,A1,A2,A3}.
  - Response: `stall` until fill, `mem_address`=0x10, then `instr`=A0. `miss_count`=1.
- Sequential hits:
  - Stimulus: after the cold fill, addresses 0x11, 0x12, 0x13 on consecutive cycles.
  - Response: `stall`=0 and `instr`=A1, A2, A3 on those cycles. `hit_count` rises by 3, `mem_enable` stays 0.
- Conflict eviction:
  - Stimulus: fill 0x10, then fetch 0x50 (same index, LINES=4), then 0x10 again.
  - Response: each is a miss. `miss_count`=3, and `mem_enable` shows 3 distinct rising edges each preceded by a low cycle.
- Back-to-back misses:
  - Stimulus: misses to 0x20 then 0x34.
  - Response: `mem_enable` is low for ≥1 cycle between requests. The second `mem_address`=0x34.
- Flush mid-miss:
  - Stimulus: line 0x10 valid; miss to 0x24; `flush` during WAIT.
  - Response: the 0x24 fill completes, and 0x24 then hits. A later fetch of 0x10 misses.
- Reset mid-miss and stray valid:
  - Stimulus: `reset` in WAIT, then `mem_valid` pulsed in IDLE with data.
  - Response: no line becomes valid, state stays IDLE, `mem_enable`=0, counters 0.
